// File: rtl/packet_packer.sv
// Packs a stream of tagged narrow segments into wide words for a FIFO-style write port.
// Optional idle-flush of partial packets is enabled with PACKET_PACKER_TIMEOUT_EN.
module packet_packer #(
   parameter int unsigned             SEGMENT_SIZE   = 8,
   parameter int unsigned             SEGMENT_COUNT  = 4,
   parameter logic [SEGMENT_SIZE-1:0] PAD_VALUE      = '0,
   parameter int unsigned             TIMEOUT_CYCLES = 255
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   output logic                                  in_full,
   input  logic                                  in_shift,
   input  logic [SEGMENT_SIZE-1:0]               in_data,
   input  logic                                  in_end,
   input  logic                                  out_full,
   output logic                                  out_shift,
   output logic [SEGMENT_SIZE*SEGMENT_COUNT-1:0] out_data,
   output logic                                  out_end
);

   localparam int unsigned       WORD_W   = SEGMENT_SIZE * SEGMENT_COUNT;
   localparam int unsigned       IDX_W    = $clog2(SEGMENT_COUNT);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(SEGMENT_COUNT - 1);
   localparam logic [WORD_W-1:0] PAD_WORD = {SEGMENT_COUNT{PAD_VALUE}};

   if (SEGMENT_COUNT < 2) begin : g_bad_count
      $error("packet_packer: SEGMENT_COUNT must be >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("packet_packer: TIMEOUT_CYCLES must be >= 1");
   end

   logic [WORD_W-1:0] r_acc;
   logic [IDX_W-1:0]  r_idx;
   logic              r_hold_valid;
   logic [WORD_W-1:0] r_out_data;
   logic              r_out_end;

   logic              w_drain;
   logic              w_accept;
   logic              w_complete;
   logic              w_flush;
   logic [WORD_W-1:0] w_merged;

   assign w_drain    = r_hold_valid & ~out_full;
   assign in_full    = r_hold_valid & out_full;
   assign w_accept   = in_shift & ~in_full;
   assign w_complete = w_accept & (in_end | (r_idx == IDX_LAST));

   // Accumulator with the incoming segment dropped into its slot
   always_comb begin
      w_merged = r_acc;
      for (int unsigned s = 0; s < SEGMENT_COUNT; s++) begin
         if (r_idx == IDX_W'(s)) begin
            w_merged[s*SEGMENT_SIZE +: SEGMENT_SIZE] = in_data;
         end
      end
   end

`ifdef PACKET_PACKER_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] r_idle;

   // Idle counter saturates at the limit; flush waits there until the hold is free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle <= '0;
      end else if (w_accept || (r_idx == '0) || w_flush) begin
         r_idle <= '0;
      end else if (r_idle != TO_W'(TIMEOUT_CYCLES)) begin
         r_idle <= r_idle + TO_W'(1);
      end
   end

   assign w_flush = (r_idx != '0) && !w_accept &&
                    (r_idle == TO_W'(TIMEOUT_CYCLES)) &&
                    (!r_hold_valid || w_drain);
`else
   assign w_flush = 1'b0;
`endif

   // Accumulator, segment index and one-entry holding register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc        <= PAD_WORD;
         r_idx        <= '0;
         r_hold_valid <= 1'b0;
         r_out_data   <= '0;
         r_out_end    <= 1'b0;
      end else if (w_complete) begin
         r_hold_valid <= 1'b1;
         r_out_data   <= w_merged;
         r_out_end    <= in_end;
         r_idx        <= '0;
         r_acc        <= PAD_WORD;
      end else if (w_flush) begin
         r_hold_valid <= 1'b1;
         r_out_data   <= r_acc;
         r_out_end    <= 1'b1;
         r_idx        <= '0;
         r_acc        <= PAD_WORD;
      end else begin
         if (w_drain) begin
            r_hold_valid <= 1'b0;
         end
         if (w_accept) begin
            r_acc <= w_merged;
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

   assign out_shift = w_drain;
   assign out_data  = r_out_data;
   assign out_end   = r_out_end;

endmodule
